// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX byte-path arbiter.
// Arbiter FSM states, byte width and index-width helper.
package uart_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int BYTE_W = 8;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TX-FIFO-side signal bundle of the UART TX arbiter.
// master = requesters/FIFO environment, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    import uart_arb_pkg::*;

    localparam int ID_W = id_w(N_REQ);

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]             req_last;
    logic [N_REQ-1:0]             req_ready;
    logic                         fifo_tx_full;
    logic [BYTE_W-1:0]            tx_byte;
    logic                         tx_valid;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;
    logic                         timeout_o;

    modport master (
        output req_valid, req_data, req_last, fifo_tx_full,
        input  req_ready, tx_byte, tx_valid, grant_id, busy, timeout_o
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_tx_full,
        output req_ready, tx_byte, tx_valid, grant_id, busy, timeout_o
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at/after ptr,
// wrapping N-1 -> 0. Returns one-hot grant, index and any-request flag.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int i = 0; i < N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX FIFO write port.
// Optional grant revoke on owner inactivity: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W = id_w(N_REQ);

    arb_state_t        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [7:0]        burst_cnt;
    logic [BYTE_W-1:0] tx_byte;
    logic              tx_valid;
    logic              timeout_q;

    logic [N_REQ-1:0]  unused_onehot;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_any;

    rr_arbiter #(
        .N (N_REQ),
        .W (ID_W)
    ) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (unused_onehot),
        .idx (pick_idx),
        .any (pick_any)
    );

    logic              own_valid;
    logic              own_last;
    logic [BYTE_W-1:0] own_data;
    logic              ready_ok;
    logic              accept;
    logic [7:0]        burst_nxt;
    logic              release_pkt;
    logic              revoke;
    logic [ID_W-1:0]   ptr_nxt;

    assign own_valid = bus.req_valid[grant_id];
    assign own_last  = bus.req_last[grant_id];
    assign own_data  = bus.req_data[grant_id];

    // Blocking on our own strobe spaces accepts 2 cycles apart,
    // so fifo_tx_full already reflects the previous write.
    assign ready_ok    = (state == ARB_GRANT) && !bus.fifo_tx_full && !tx_valid;
    assign accept      = ready_ok && own_valid;
    assign burst_nxt   = burst_cnt + 8'd1;
    assign release_pkt = accept && (own_last || (burst_nxt == 8'(MAX_BURST)));
    assign ptr_nxt     = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] idle_cnt;
    logic            idle_tick;

    assign idle_tick = (state == ARB_GRANT) && !own_valid && !bus.fifo_tx_full;
    assign revoke    = idle_tick && (idle_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if ((state != ARB_GRANT) || accept || revoke) begin
            idle_cnt <= '0;
        end else if (idle_tick) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    localparam bit unused_timeout = (TIMEOUT > 0);

    assign revoke = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            tx_byte   <= '0;
            tx_valid  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tx_valid  <= accept;
            tx_byte   <= accept ? own_data : '0;
            timeout_q <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (accept) begin
                        burst_cnt <= burst_nxt;
                    end
                    // accept and revoke are exclusive: one pointer step
                    if (release_pkt || revoke) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= ptr_nxt;
                    end
                    timeout_q <= revoke;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_ok ? (N_REQ'(1) << grant_id) : '0;
    assign bus.tx_byte   = tx_byte;
    assign bus.tx_valid  = tx_valid;
    assign bus.grant_id  = grant_id;
    assign bus.busy      = (state == ARB_GRANT);
    assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (N_REQ=4, MAX_BURST=16, TIMEOUT=8).
// Expected (id, byte) order is pushed per test; a monitor pops on tx_valid.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (16),
        .TIMEOUT   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] sb[$];
    logic [11:0] e;
    logic [8:0]  rbuf[N][64];
    int          rhead[N] = '{default: 0};
    int          rtail[N] = '{default: 0};
    logic [N-1:0] acc = '0;
    int          last_tx = -1;
    int          to_cnt  = 0;
    int          to_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] b);
        sb.push_back({4'(id), b});
    endtask

    task automatic load(input int id, input logic [7:0] b, input logic last);
        rbuf[id][rtail[id]] = {last, b};
        rtail[id]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (rhead[i] < rtail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || pending()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s drain timeout left=%0d required=0",
                     name, sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        sb.delete();
        last_tx = -1;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Requester model: presents queue heads, advances on handshake
    initial begin
        bus.req_valid    = '0;
        bus.req_last     = '0;
        bus.req_data     = '0;
        bus.fifo_tx_full = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (acc[i] && rhead[i] < rtail[i]) rhead[i]++;
            for (int i = 0; i < N; i++) begin
                if (rhead[i] < rtail[i]) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_last[i]  = rbuf[i][rhead[i]][8];
                    bus.req_data[i]  = rbuf[i][rhead[i]][7:0];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                    bus.req_data[i]  = '0;
                end
            end
            #1;
            acc = bus.req_valid & bus.req_ready;
        end
    end

    // Monitor: scoreboard pop on every FIFO strobe
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.tx_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx byte=%0h id=%0d required=none",
                             bus.tx_byte, bus.grant_id);
                end else begin
                    e = sb.pop_front();
                    chk("tx_byte", 32'(bus.tx_byte), 32'(e[7:0]));
                    chk("tx_id", 32'(bus.grant_id), 32'(e[11:8]));
                end
                if (last_tx >= 0)
                    chk("tx_gap_ge2", 32'((cyc - last_tx) >= 2), 32'd1);
                last_tx = cyc;
            end else begin
                chk("tx_byte_idle", 32'(bus.tx_byte), 32'd0);
            end
            if (bus.timeout_o) begin
                to_cnt++;
                to_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;

        // Single requester, 3-byte packet
        push_exp(1, 8'h41);
        push_exp(1, 8'h42);
        push_exp(1, 8'h43);
        load(1, 8'h41, 1'b0);
        load(1, 8'h42, 1'b0);
        load(1, 8'h43, 1'b1);
        wait_drain("pkt3", 100);
        chk("pkt3_busy_low", 32'(bus.busy), 32'd0);

        // All four, pointer 0 -> 0,1,2,3, then pointer back to 0
        do_reset();
        for (int i = 0; i < N; i++) push_exp(i, 8'hA0 + 8'(i));
        for (int i = 0; i < N; i++) load(i, 8'hA0 + 8'(i), 1'b1);
        wait_drain("rr4", 100);
        push_exp(0, 8'hB0);
        push_exp(3, 8'hB3);
        load(3, 8'hB3, 1'b1);
        load(0, 8'hB0, 1'b1);
        wait_drain("rr_wrap", 100);

        // MAX_BURST forced release, pending requester served in between
        for (int k = 0; k < 16; k++) push_exp(2, 8'h60 + 8'(k));
        push_exp(0, 8'hC0);
        push_exp(0, 8'hC1);
        for (int k = 16; k < 20; k++) push_exp(2, 8'h60 + 8'(k));
        for (int k = 0; k < 20; k++) load(2, 8'h60 + 8'(k), k == 19);
        repeat (5) @(negedge clk);
        load(0, 8'hC0, 1'b0);
        load(0, 8'hC1, 1'b1);
        wait_drain("burst", 300);

        // FIFO full mid-packet
        for (int k = 0; k < 6; k++) push_exp(1, 8'h80 + 8'(k));
        for (int k = 0; k < 6; k++) load(1, 8'h80 + 8'(k), k == 5);
        n = 0;
        while (sb.size() > 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("full_reach_2bytes", 32'(n < 100), 32'd1);
        bus.fifo_tx_full = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("full_ready", 32'(bus.req_ready), 32'd0);
            chk("full_tx_valid", 32'(bus.tx_valid), 32'd0);
            chk("full_grant", 32'(bus.grant_id), 32'd1);
        end
        bus.fifo_tx_full = 1'b0;
        wait_drain("full_resume", 100);

        // Owner goes quiet after one byte; requester 1 waits
        to_cnt = 0;
`ifdef UART_ARB_TIMEOUT_EN
        push_exp(0, 8'hD0);
        push_exp(1, 8'hD1);
        load(0, 8'hD0, 1'b0);
        load(1, 8'hD1, 1'b1);
        n = 0;
        while (sb.size() > 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        t0 = last_tx;
        wait_drain("timeout", 100);
        chk("timeout_pulses", 32'(to_cnt), 32'd1);
        chk("timeout_delay", 32'(to_cyc - t0), 32'd8);
`else
        push_exp(0, 8'hD0);
        load(0, 8'hD0, 1'b0);
        load(1, 8'hD1, 1'b1);
        t0 = 0;
        repeat (40) @(negedge clk);
        chk("hold_sb_empty", 32'(sb.size()), 32'd0);
        chk("hold_busy", 32'(bus.busy), 32'd1);
        chk("hold_grant", 32'(bus.grant_id), 32'd0 + 32'(t0));
        chk("hold_no_timeout", 32'(to_cnt), 32'd0);
`endif
        do_reset();

        // Reset lands while a handshake is pending
        load(3, 8'hE3, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[3] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_ready_seen", 32'(n < 50), 32'd1);
        reset = 1'b1;
        rhead[3] = 0;
        rtail[3] = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_tx_valid", 32'(bus.tx_valid), 32'd0);
            chk("rst_mid_busy", 32'(bus.busy), 32'd0);
            chk("rst_mid_grant", 32'(bus.grant_id), 32'd0);
            chk("rst_mid_ready", 32'(bus.req_ready), 32'd0);
            chk("rst_mid_byte", 32'(bus.tx_byte), 32'd0);
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
